// File: rtl/rcv_fifo_pkg.sv
// Shared sizing for the receive FIFO: default geometry and width helpers
// used by the pointer controller, the FIFO RAM and the entry readers.
package rcv_fifo_pkg;

    localparam int RCV_FIFO_DEPTH = 8;
    localparam int RCV_FIFO_SIDES = 4;

    // Entry index width; DEPTH is a power of two and at least 2.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Side index width; a single-sided entry still needs one bit.
    function automatic int side_w(input int sides);
        return (sides > 1) ? $clog2(sides) : 1;
    endfunction

    // Occupancy width must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a counter running 0..max.
    function automatic int ctr_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/rcv_wrap_counter.sv
// Modulo-(MAX+1) up-counter. carry flags the step that wraps back to zero
// in the current cycle (used to chain counters without a bubble); wrap is
// the registered copy of carry, high for one cycle after the wrap.
module rcv_wrap_counter
    import rcv_fifo_pkg::*;
#(
    parameter int MAX = 3,
    localparam int W = ctr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         carry,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign carry = en & (value == LAST);

    // Advance on enable, fold back to zero after LAST, register the wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= carry;
            if (en) begin
                value <= carry ? '0 : value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcv_fifo_ptr_ctrl.sv
// Receive FIFO pointer controller. Sub-words fill the tail entry one side
// at a time; whole entries are popped from the head. Occupancy counts only
// complete entries, so a partially filled tail is never readable.
module rcv_fifo_ptr_ctrl
    import rcv_fifo_pkg::*;
#(
    parameter int DEPTH = RCV_FIFO_DEPTH,
    parameter int SIDES = RCV_FIFO_SIDES,
    localparam int IDX_W  = idx_w(DEPTH),
    localparam int SIDE_W = side_w(SIDES),
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [IDX_W-1:0]  tail_idx,
    output logic [SIDE_W-1:0] tail_side,
    output logic [IDX_W-1:0]  head_idx,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              partial,
    output logic              entry_done,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic             flush;
    logic             wr_acc;
    logic             rd_acc;
    logic             entry_cmp;
    logic [CNT_W-1:0] count_nxt;
    logic             partial_nxt;
    logic             tail_carry_unused;
    logic             tail_wrap_unused;
    logic             head_carry_unused;
    logic             head_wrap_unused;

    assign flush  = rst | sync_clr;
    // full/empty are the registered pre-update state of this cycle, so a
    // pop while full still rejects a concurrent write.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Side counter: its same-cycle carry is the entry-complete event and
    // steps the tail entry; its registered wrap is the entry_done pulse.
    rcv_wrap_counter #(.MAX(SIDES - 1)) u_side_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .en    (wr_acc),
        .value (tail_side),
        .carry (entry_cmp),
        .wrap  (entry_done)
    );

    rcv_wrap_counter #(.MAX(DEPTH - 1)) u_tail_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .en    (entry_cmp),
        .value (tail_idx),
        .carry (tail_carry_unused),
        .wrap  (tail_wrap_unused)
    );

    rcv_wrap_counter #(.MAX(DEPTH - 1)) u_head_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .en    (rd_acc),
        .value (head_idx),
        .carry (head_carry_unused),
        .wrap  (head_wrap_unused)
    );

    // Next occupancy: a completion and a pop in the same cycle cancel out.
    always_comb begin
        count_nxt = count;
        if (entry_cmp && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !entry_cmp) begin
            count_nxt = count - 1'b1;
        end
        partial_nxt = (partial | wr_acc) & ~entry_cmp;
    end

    // Register occupancy, its flags and the sticky error bits together.
    always_ff @(posedge clk) begin
        if (flush) begin
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            partial   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            full      <= (count_nxt == CNT_MAX);
            empty     <= (count_nxt == '0);
            partial   <= partial_nxt;
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

endmodule

// File: tb/tb_rcv_fifo_ptr_ctrl.sv
// Bench for rcv_fifo_ptr_ctrl with DEPTH = 4, SIDES = 4. The reference model
// tracks total accepted sub-words and total pops; every pointer and flag is
// derived from those two totals with plain arithmetic.
module tb_rcv_fifo_ptr_ctrl;

    localparam int D = 4;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sync_clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [1:0] tail_idx;
    logic [1:0] tail_side;
    logic [1:0] head_idx;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       partial;
    logic       entry_done;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_sub  = 0;
    int m_pops = 0;
    bit m_done = 0;
    bit m_ovf  = 0;
    bit m_unf  = 0;

    rcv_fifo_ptr_ctrl #(.DEPTH(D), .SIDES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_clr   (sync_clr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .tail_idx   (tail_idx),
        .tail_side  (tail_side),
        .head_idx   (head_idx),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .partial    (partial),
        .entry_done (entry_done),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        return m_sub / S - m_pops;
    endfunction

    function automatic logic [14:0] m_vec();
        int c;
        c = m_count();
        return {2'((m_sub / S) % D), 2'(m_sub % S), 2'(m_pops % D), 3'(c),
                c == D, c == 0, (m_sub % S) != 0, m_done, m_ovf, m_unf};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, and return
    // 1 time unit after the edge with the DUT outputs settled.
    task automatic step(input logic w, input logic r, input logic rs, input logic sc);
        int  c;
        bit  wacc;
        bit  racc;
        wr_en = w; rd_en = r; rst = rs; sync_clr = sc;
        @(posedge clk);
        if (rs || sc) begin
            m_sub = 0; m_pops = 0; m_done = 0; m_ovf = 0; m_unf = 0;
        end else begin
            c = m_count();
            wacc = w && (c != D);
            racc = r && (c != 0);
            m_done = wacc && (m_sub % S == S - 1);
            if (w && c == D) m_ovf = 1;
            if (r && c == 0) m_unf = 1;
            if (wacc) m_sub++;
            if (racc) m_pops++;
        end
        #1;
        wr_en = 0; rd_en = 0; rst = 0; sync_clr = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 1, 0);
        n_tests++;
        if ({tail_idx, tail_side, head_idx, count, full, empty, partial,
             entry_done, overflow, underflow} !== 15'b00_00_00_000_0_1_0_0_0_0) begin
            n_fail++;
            $display("FAIL reset_state got %b %b %b %0d f%b e%b p%b d%b o%b u%b want all 0 with empty=1",
                     tail_idx, tail_side, head_idx, count, full, empty, partial,
                     entry_done, overflow, underflow);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_tests++;
        if (tail_side !== 2'd2 || partial !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_side got side=%0d partial=%b want side=2 partial=1", tail_side, partial);
        end
        step(1, 0, 1, 0);
        n_tests++;
        if (tail_side !== 2'd0 || partial !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_entry got side=%0d partial=%b count=%0d want 0 0 0", tail_side, partial, count);
        end
    endtask

    task automatic test_entry_fill();
        step(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0);
            n_tests++;
            if (tail_side !== 2'(i % 4) || entry_done !== (i == 4)) begin
                n_fail++;
                $display("FAIL fill_step%0d got side=%0d done=%b want side=%0d done=%b",
                         i, tail_side, entry_done, i % 4, i == 4);
            end
        end
        n_tests++;
        if (tail_idx !== 2'd1 || count !== 3'd1 || empty !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_entry got tail=%0d count=%0d empty=%b full=%b want 1 1 0 0",
                     tail_idx, count, empty, full);
        end
        step(0, 0, 0, 0);
        n_tests++;
        if (entry_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_pulse got done=%b want 0", entry_done);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        n_tests++;
        if (full !== 1'b1 || count !== 3'd4 || tail_idx !== 2'd0 || tail_side !== 2'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full got full=%b count=%0d tail=%0d side=%0d ovf=%b want 1 4 0 0 0",
                     full, count, tail_idx, tail_side, overflow);
        end
        step(1, 0, 0, 0);
        n_tests++;
        if (overflow !== 1'b1 || count !== 3'd4 || tail_idx !== 2'd0 || tail_side !== 2'd0 || entry_done !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reject got ovf=%b count=%0d tail=%0d side=%0d done=%b want 1 4 0 0 0",
                     overflow, count, tail_idx, tail_side, entry_done);
        end
        step(0, 0, 0, 0);
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_tests++;
        if (count !== 3'd2 || tail_idx !== 2'd3 || head_idx !== 2'd1 || entry_done !== 1'b1 || tail_side !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b got count=%0d tail=%0d head=%0d done=%b side=%0d want 2 3 1 1 0",
                     count, tail_idx, head_idx, entry_done, tail_side);
        end
    endtask

    task automatic test_full_boundary();
        step(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_tests++;
        if (count !== 3'd3 || full !== 1'b0 || head_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL full_minus1_pop got count=%0d full=%b head=%0d want 3 0 1", count, full, head_idx);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_tests++;
        if (count !== 3'd3 || tail_side !== 2'd0 || overflow !== 1'b1 || head_idx !== 2'd2 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_wr got count=%0d side=%0d ovf=%b head=%0d full=%b want 3 0 1 2 0",
                     count, tail_side, overflow, head_idx, full);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        n_tests++;
        if (head_idx !== 2'd0 || underflow !== 1'b1 || count !== 3'd0 || tail_side !== 2'd2) begin
            n_fail++;
            $display("FAIL unf_reject got head=%0d unf=%b count=%0d side=%0d want 0 1 0 2",
                     head_idx, underflow, count, tail_side);
        end
        step(0, 0, 0, 1);
        n_tests++;
        if (underflow !== 1'b0 || tail_side !== 2'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_sync_clr got unf=%b side=%0d empty=%b want 0 0 1", underflow, tail_side, empty);
        end
    endtask

    task automatic test_random_bursts();
        logic [14:0] got;
        logic [14:0] exp;
        step(0, 0, 1, 0);
        for (int b = 0; b < 40; b++) begin
            int len;
            int mode;
            len  = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            for (int k = 0; k < len; k++) begin
                logic w;
                logic r;
                case (mode)
                    0: begin w = 1'b1; r = ($urandom_range(0, 7) == 0); end
                    1: begin w = ($urandom_range(0, 3) == 0); r = 1'b1; end
                    2: begin w = 1'($urandom); r = 1'($urandom); end
                    default: begin w = 1'b1; r = 1'b1; end
                endcase
                step(w, r, 1'b0, ($urandom_range(0, 63) == 0));
                got = {tail_idx, tail_side, head_idx, count, full, empty, partial,
                       entry_done, overflow, underflow};
                exp = m_vec();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rand_b%0d_c%0d got tail,side,head,count,f,e,p,d,o,u=%b want %b",
                             b, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry_fill();
        test_overflow();
        test_back_to_back();
        test_full_boundary();
        test_underflow();
        test_random_bursts();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
